// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory port between an I-cache and a D-cache.
// One transaction is in flight at a time. The D-cache wins ties, and a starvation guard eventually lets the I-cache through.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icReq,
    input  logic [15:0] icAddr,
    input  logic        dcReq,
    input  logic        dcWr,
    input  logic [15:0] dcAddr,
    input  logic [15:0] dcDataIn,
    input  logic [15:0] memDataOut,
    output logic        memRd,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memDataIn,
    output logic        icDone,
    output logic        dcDone,
    output logic [15:0] rdData,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    localparam int unsigned   STARVE_W   = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [3:0]    WAIT_INIT  = 4'(LATENCY - 1);

    state_e              state_q,  state_d;
    owner_e              owner_q,  owner_d;
    logic [15:0]         addr_q,   addr_d;
    logic [15:0]         data_q,   data_d;
    logic                wr_q,     wr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [3:0]          wait_q,   wait_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path through the case statement can infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        memRd     = 1'b0;
        memWr     = 1'b0;
        memAddr   = '0;
        memDataIn = '0;
        icDone    = 1'b0;
        dcDone    = 1'b0;
        rdData    = '0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (dcReq && !(icReq && (starve_q == STARVE_LIM))) begin
                    owner_d = OWN_D;
                    addr_d  = dcAddr;
                    wr_d    = dcWr;
                    data_d  = dcWr ? dcDataIn : '0;
                    if (icReq && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    state_d = S_ISSUE;
                end else if (icReq) begin
                    owner_d  = OWN_I;
                    addr_d   = icAddr;
                    wr_d     = 1'b0;
                    data_d   = '0;
                    starve_d = '0;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                memRd     = ~wr_q;
                memWr     = wr_q;
                memAddr   = addr_q;
                memDataIn = data_q;
                wait_d    = WAIT_INIT;
                state_d   = (WAIT_INIT == 4'd0) ? S_DONE : S_WAIT;
            end

            S_WAIT: begin
                if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            S_DONE: begin
                icDone  = (owner_q == OWN_I);
                dcDone  = (owner_q == OWN_D);
                // Read data lands exactly LATENCY cycles after the command, which is this cycle, so it is forwarded directly.
                rdData  = wr_q ? '0 : memDataOut;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_I;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            starve_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, 4, cycles from memory command to read data valid on memDataOut (legal 1..15).
REQ-002 Parameter: STARVE_MAX, 3, consecutive D grants allowed while icReq is pending before I is forced.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 icReq  input  1  instruction-cache fill request; held high until icDone is sampled.
REQ-006 icAddr  input  16  instruction fetch address.
REQ-007 dcReq  input  1  data-cache request; held high until dcDone is sampled.
REQ-008 dcWr  input  1  1 = store, 0 = load; valid with dcReq.
REQ-009 dcAddr  input  16  data address.
REQ-010 dcDataIn  input  16  store data.
REQ-011 memDataOut  input  16  read data from shared memory, valid exactly LATENCY cycles after a read command.
REQ-012 memRd  output  1  one-cycle read command to shared memory.
REQ-013 memWr  output  1  one-cycle write command to shared memory.
REQ-014 memAddr  output  16  address driven with memRd/memWr.
REQ-015 memDataIn  output  16  write data driven with memWr.
REQ-016 icDone  output  1  one-cycle completion pulse to I-cache.
REQ-017 dcDone  output  1  one-cycle completion pulse to D-cache.
REQ-018 rdData  output  16  captured read data, valid in the cycle of icDone/dcDone (zero for stores).
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; owner register (I or D) records the granted requester.
REQ-021 IDLE: if any request is high, latch owner and its address/wr/data, go to ISSUE next cycle; else stay.
REQ-022 Arbitration: D wins when both requests are high, unless the starve counter equals STARVE_MAX, in which case I wins.
REQ-023 Starve counter (2+ bits, saturating at STARVE_MAX) increments on each D grant made while icReq is high, clears on any I grant, holds otherwise.
REQ-024 ISSUE: assert exactly one of memRd (I, or D with dcWr=0) or memWr (D with dcWr=1) for one cycle with latched memAddr/memDataIn; go to WAIT.
REQ-025 WAIT: down-counter loaded with LATENCY-1 at ISSUE; go to DONE when counter reaches 0; for reads capture memDataOut into rdData on that transition.
REQ-026 Stores SHALL also wait LATENCY cycles (memory busy), and rdData SHALL be 0x0000 for store completions.
REQ-027 DONE: pulse icDone or dcDone (per owner) for exactly one cycle, then IDLE; requests are not sampled in DONE.
REQ-028 Latency: request sampled in IDLE at cycle t -> command at t+1 -> done at t+1+LATENCY -> IDLE at t+2+LATENCY.
REQ-029 A request still high in the cycle after DONE SHALL be treated as a new request.
REQ-030 Request inputs changing while not in IDLE SHALL be ignored; latched values drive memory.
REQ-031 memRd, memWr, icDone, dcDone SHALL never be high simultaneously with each other.
REQ-032 memAddr/memDataIn SHALL be 0x0000 whenever memRd and memWr are both low.

Reset
REQ-033 rst high at a posedge SHALL force IDLE, owner=I, starve counter=0, wait counter=0, rdData=0x0000, and all outputs low/zero next cycle.
REQ-034 rst during ISSUE/WAIT/DONE SHALL abort the transaction with no done pulse; pending requests are re-arbitrated after rst deasserts.

Verification
REQ-035 LATENCY=4; icReq=1, icAddr=0x0040 at cycle 0, memDataOut=0xBEEF at cycle 5 -> memRd=1, memAddr=0x0040 at cycle 1; icDone=1, rdData=0xBEEF at cycle 5; busy low at cycle 6.
REQ-036 icReq and dcReq (dcWr=1, dcAddr=0x1000, dcDataIn=0x1234) high at cycle 0 -> memWr=1, memAddr=0x1000, memDataIn=0x1234 at cycle 1; dcDone at cycle 5 with rdData=0x0000; I read command at cycle 7.
REQ-037 dcReq and icReq held high continuously -> grant order D,D,D,I,D,D,D,I; icDone occurs within 4 transactions.
REQ-038 rst asserted at cycle 3 of an I read -> no icDone, all outputs zero at cycle 4; with icReq still high after rst drops, fresh memRd one cycle after first IDLE cycle.
REQ-039 dcAddr changed from 0x0010 to 0x0020 during WAIT -> memAddr in ISSUE remains 0x0010; second address issued only as a new request.
REQ-040 Every simulation cycle checked: at most one of memRd/memWr/icDone/dcDone high; done pulses exactly one cycle wide.
